// File: rtl/mem_stream_reader.sv
// mem_stream_reader: read-side sequencer for the scratch memory.
// On start_i it walks len_i words from base_addr_i. It issues at most one
// combinational read per cycle and returns the words on a valid/ready stream
// with a last flag. A single output register decouples the memory read from
// downstream backpressure.
`timescale 1ns/1ps
module mem_stream_reader #(
  parameter int MEM_ADDR_WIDTH = 10,
  parameter int MEM_DATA_WIDTH = 16,
  parameter int MEM_DEPTH      = 1 << MEM_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic [MEM_ADDR_WIDTH-1:0] base_addr_i,
  input  logic [MEM_ADDR_WIDTH:0]   len_i,
  input  logic                      abort_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic [MEM_ADDR_WIDTH-1:0] raddr_o,
  output logic                      ren_o,
  input  logic [MEM_DATA_WIDTH-1:0] rdata_i,
  output logic                      m_valid_o,
  output logic [MEM_DATA_WIDTH-1:0] m_data_o,
  output logic                      m_last_o,
  input  logic                      m_ready_i
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [MEM_ADDR_WIDTH:0]   DEPTH_CNT = (MEM_ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [MEM_ADDR_WIDTH:0]   ONE_CNT   = (MEM_ADDR_WIDTH+1)'(1);
  localparam logic [MEM_ADDR_WIDTH-1:0] LAST_ADDR = MEM_ADDR_WIDTH'(MEM_DEPTH - 1);

  logic [1:0]                state;
  logic [MEM_ADDR_WIDTH-1:0] addr;
  logic [MEM_ADDR_WIDTH:0]   rem;
  logic [MEM_ADDR_WIDTH:0]   len_clamped;
  logic                      slot_free;
  logic                      handshake;
  logic                      last_read;

  // A request longer than the memory reads every word exactly once.
  always_comb begin
    len_clamped = (len_i > DEPTH_CNT) ? DEPTH_CNT : len_i;
  end

  // The output slot can take a new word when it is empty or being drained this cycle.
  assign slot_free = !m_valid_o || m_ready_i;
  assign handshake = m_valid_o && m_ready_i;
  assign last_read = (rem == ONE_CNT);

  assign ren_o   = (state == ST_RUN) && slot_free && !abort_i;
  assign raddr_o = addr;
  assign busy_o  = (state != ST_IDLE);

  // Sequencer state, address/count registers and the single-entry output slot.
  // NOTE: every register here uses <= so that all updates see pre-edge values;
  // mixing in blocking assignments would make, e.g., m_last_o observe the
  // already-decremented rem.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      addr      <= '0;
      rem       <= '0;
      done_o    <= 1'b0;
      m_valid_o <= 1'b0;
      m_data_o  <= '0;
      m_last_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            addr <= base_addr_i;
            rem  <= len_clamped;
            if (len_clamped == '0) begin
              done_o <= 1'b1;
            end else begin
              state <= ST_RUN;
            end
          end
        end

        ST_RUN, ST_DRAIN: begin
          if (abort_i) begin
            state     <= ST_IDLE;
            rem       <= '0;
            m_valid_o <= 1'b0;
            m_last_o  <= 1'b0;
          end else if (ren_o) begin
            m_data_o  <= rdata_i;
            m_valid_o <= 1'b1;
            m_last_o  <= last_read;
            addr      <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
            rem       <= rem - ONE_CNT;
            if (last_read) begin
              state <= ST_DRAIN;
            end
          end else if (handshake) begin
            m_valid_o <= 1'b0;
            // Only the final word ever carries m_last_o, so its acceptance ends the block.
            if (m_last_o) begin
              state    <= ST_IDLE;
              m_last_o <= 1'b0;
              done_o   <= 1'b1;
            end
          end
        end

        default: begin
          state     <= ST_IDLE;
          m_valid_o <= 1'b0;
          m_last_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stream_reader.sv
// Testbench for mem_stream_reader. The scratch memory is modelled as an
// array with combinational read. Each burst's expected beats are a queue built
// from the memory contents, the base address and the clamped length.
`timescale 1ns/1ps
module tb_mem_stream_reader;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [9:0]  base_addr_i;
  logic [10:0] len_i;
  logic        abort_i;
  logic        busy_o;
  logic        done_o;
  logic [9:0]  raddr_o;
  logic        ren_o;
  logic [15:0] rdata_i;
  logic        m_valid_o;
  logic [15:0] m_data_o;
  logic        m_last_o;
  logic        m_ready_i;

  logic [15:0] mem [1024];

  int total;
  int passed;

  mem_stream_reader #(
    .MEM_ADDR_WIDTH(10),
    .MEM_DATA_WIDTH(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (start_i),
    .base_addr_i(base_addr_i),
    .len_i      (len_i),
    .abort_i    (abort_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .raddr_o    (raddr_o),
    .ren_o      (ren_o),
    .rdata_i    (rdata_i),
    .m_valid_o  (m_valid_o),
    .m_data_o   (m_data_o),
    .m_last_o   (m_last_o),
    .m_ready_i  (m_ready_i)
  );

  assign rdata_i = mem[raddr_o];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // rmode: 0 = always ready, 1 = ready low on the 2nd and 3rd beat cycles,
  // 2 = random 30% stall. abort_after >= 0 raises abort_i once that many
  // beats were accepted. poke re-pulses start_i mid-burst.
  task automatic run_burst(input string name, input int base, input int len,
                           input int rmode, input int abort_after, input bit poke);
    logic [15:0] exp_q[$];
    logic [15:0] exp_word;
    logic [15:0] prev_data;
    logic        prev_last;
    logic        prev_stall;
    int          n;
    int          beats;
    int          reads;
    bit          finished;
    n          = (len > 1024) ? 1024 : len;
    beats      = 0;
    reads      = 0;
    finished   = 1'b0;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_last  = 1'b0;
    for (int i = 0; i < n; i++) exp_q.push_back(mem[(base + i) % 1024]);

    @(negedge clk);
    check({name, "_idle_before"}, 32'(busy_o), 32'd0);
    start_i     = 1'b1;
    base_addr_i = 10'(base);
    len_i       = 11'(len);
    m_ready_i   = 1'b1;
    abort_i     = 1'b0;
    @(negedge clk);
    start_i     = 1'b0;
    base_addr_i = 10'($urandom);
    len_i       = 11'($urandom);

    if (n == 0) begin
      #1;
      check({name, "_zero_done"}, 32'(done_o), 32'd1);
      check({name, "_zero_busy"}, 32'(busy_o), 32'd0);
      check({name, "_zero_valid"}, 32'(m_valid_o), 32'd0);
      check({name, "_zero_ren"}, 32'(ren_o), 32'd0);
      @(negedge clk);
      #1;
      check({name, "_zero_done_once"}, 32'(done_o), 32'd0);
      check({name, "_zero_valid2"}, 32'(m_valid_o), 32'd0);
      return;
    end

    for (int iter = 0; iter < 4 * n + 50; iter++) begin
      case (rmode)
        0:       m_ready_i = 1'b1;
        1:       m_ready_i = !(iter == 2 || iter == 3);
        default: m_ready_i = ($urandom_range(99) >= 30);
      endcase
      abort_i     = (abort_after >= 0) && (beats == abort_after);
      start_i     = poke && (iter == 3);
      base_addr_i = 10'($urandom);
      len_i       = 11'($urandom_range(1, 20));
      #1;

      if (iter == 0) begin
        check({name, "_busy_start"}, 32'(busy_o), 32'd1);
        check({name, "_valid_start"}, 32'(m_valid_o), 32'd0);
      end
      if (prev_stall) begin
        check({name, "_hold_valid"}, 32'(m_valid_o), 32'd1);
        check({name, "_hold_data"}, 32'(m_data_o), 32'(prev_data));
        check({name, "_hold_last"}, 32'(m_last_o), 32'(prev_last));
      end
      if (m_valid_o && !m_ready_i)
        check({name, "_ren_when_full"}, 32'(ren_o), 32'd0);
      if (ren_o) begin
        check({name, "_raddr"}, 32'(raddr_o), 32'((base + reads) % 1024));
        reads++;
      end

      if (abort_i) begin
        check({name, "_ren_abort"}, 32'(ren_o), 32'd0);
        @(negedge clk);
        abort_i = 1'b0;
        start_i = 1'b0;
        #1;
        check({name, "_abort_busy"}, 32'(busy_o), 32'd0);
        check({name, "_abort_valid"}, 32'(m_valid_o), 32'd0);
        check({name, "_abort_last"}, 32'(m_last_o), 32'd0);
        check({name, "_abort_done"}, 32'(done_o), 32'd0);
        @(negedge clk);
        #1;
        check({name, "_abort_done2"}, 32'(done_o), 32'd0);
        check({name, "_abort_beats"}, 32'(beats), 32'(abort_after));
        finished = 1'b1;
        break;
      end

      if (m_valid_o && m_ready_i) begin
        if (exp_q.size() == 0) begin
          check({name, "_extra_beat"}, 32'd1, 32'd0);
          finished = 1'b1;
          break;
        end
        exp_word = exp_q.pop_front();
        check({name, "_data"}, 32'(m_data_o), 32'(exp_word));
        check({name, "_last"}, 32'(m_last_o), 32'(exp_q.size() == 0));
        if (rmode == 0) check({name, "_back_to_back"}, 32'(iter), 32'(beats + 1));
        beats++;
        if (m_last_o) begin
          @(negedge clk);
          start_i   = 1'b0;
          m_ready_i = 1'b0;
          #1;
          check({name, "_done"}, 32'(done_o), 32'd1);
          check({name, "_end_busy"}, 32'(busy_o), 32'd0);
          check({name, "_end_valid"}, 32'(m_valid_o), 32'd0);
          check({name, "_end_last"}, 32'(m_last_o), 32'd0);
          check({name, "_reads"}, 32'(reads), 32'(n));
          check({name, "_beats"}, 32'(beats), 32'(n));
          @(negedge clk);
          #1;
          check({name, "_done_once"}, 32'(done_o), 32'd0);
          check({name, "_ren_idle"}, 32'(ren_o), 32'd0);
          finished = 1'b1;
          break;
        end
      end

      prev_stall = m_valid_o && !m_ready_i;
      prev_data  = m_data_o;
      prev_last  = m_last_o;
      @(negedge clk);
    end

    if (!finished) check({name, "_timeout"}, 32'd0, 32'd1);
    start_i   = 1'b0;
    abort_i   = 1'b0;
    m_ready_i = 1'b1;
  endtask

  initial begin
    total       = 0;
    passed      = 0;
    rst_n       = 1'b0;
    start_i     = 1'b0;
    base_addr_i = '0;
    len_i       = '0;
    abort_i     = 1'b0;
    m_ready_i   = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i + 'h100);

    #12;
    check("reset_busy", 32'(busy_o), 32'd0);
    check("reset_done", 32'(done_o), 32'd0);
    check("reset_ren", 32'(ren_o), 32'd0);
    check("reset_raddr", 32'(raddr_o), 32'd0);
    check("reset_valid", 32'(m_valid_o), 32'd0);
    check("reset_data", 32'(m_data_o), 32'd0);
    check("reset_last", 32'(m_last_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_burst("basic", 5, 4, 0, -1, 1'b0);
    run_burst("backpressure", 5, 4, 1, -1, 1'b0);
    run_burst("wrap", 1022, 3, 0, -1, 1'b0);
    run_burst("wrap4", 1022, 4, 2, -1, 1'b0);
    run_burst("clamp", 37, 1100, 0, -1, 1'b0);
    run_burst("full", 0, 1024, 2, -1, 1'b0);
    run_burst("len1", 1023, 1, 2, -1, 1'b0);
    run_burst("zero", 9, 0, 0, -1, 1'b0);
    run_burst("busy_start", 200, 8, 0, -1, 1'b1);
    run_burst("abort", 300, 6, 0, 2, 1'b0);
    run_burst("after_abort", 400, 5, 0, -1, 1'b0);

    // Asynchronous reset between clock edges in the middle of a burst.
    @(negedge clk);
    start_i     = 1'b1;
    base_addr_i = 10'd100;
    len_i       = 11'd8;
    @(negedge clk);
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_busy", 32'(busy_o), 32'd0);
    check("async_done", 32'(done_o), 32'd0);
    check("async_ren", 32'(ren_o), 32'd0);
    check("async_raddr", 32'(raddr_o), 32'd0);
    check("async_valid", 32'(m_valid_o), 32'd0);
    check("async_data", 32'(m_data_o), 32'd0);
    check("async_last", 32'(m_last_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("async_done_after", 32'(done_o), 32'd0);
    run_burst("after_reset", 600, 6, 2, -1, 1'b0);

    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    for (int t = 0; t < 8; t++)
      run_burst("random", int'($urandom_range(1023)), int'($urandom_range(1, 40)), 2, -1, 1'b0);
    run_burst("random_abort", int'($urandom_range(1023)), 12, 2, 5, 1'b0);
    run_burst("random_poke", int'($urandom_range(1023)), 10, 2, -1, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
